// File: rtl/ofdm_pkg.sv
// Shared types and helpers for the OFDM symbol mapper: sample/word types,
// FSM state encoding and the QPSK point mapping.
package ofdm_pkg;

  localparam int NPTS_DEF = 128;
  localparam int BIN0_DEF = 4;

  typedef logic signed [16:0] sample_t;
  typedef logic [47:0]        word_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EMIT,
    ST_GAP
  } state_t;

  typedef struct packed {
    sample_t re;
    sample_t im;
  } iq_t;

  // Bit 0 of the pair selects the real sign, bit 1 the imaginary sign.
  function automatic iq_t qpsk_map(input logic [1:0] pair, input sample_t amp);
    iq_t r;
    r.re = pair[0] ? -amp : amp;
    r.im = pair[1] ? -amp : amp;
    return r;
  endfunction

endpackage

// File: rtl/ofdm_word_fifo.sv
// Two-entry payload buffer. o_ready is a registered not-full flag that is
// held low while in reset, so writes are only taken when it was high pre-edge.
module ofdm_word_fifo
  import ofdm_pkg::*;
(
  input  logic  i_clk,
  input  logic  i_rst_n,
  input  logic  i_push,
  input  logic  i_pop,
  input  word_t i_data,
  output word_t o_data,
  output logic  o_empty,
  output logic  o_ready
);

  word_t      r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;
  logic       r_ready;
  logic [1:0] w_count_nxt;
  logic       w_wr;
  logic       w_rd;

  assign w_wr        = i_push & r_ready;
  assign w_rd        = i_pop & (r_count != 2'd0);
  assign w_count_nxt = r_count + {1'b0, w_wr} - {1'b0, w_rd};

  assign o_data  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == 2'd0);
  assign o_ready = r_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      r_ready  <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_rd) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt != 2'd2);
    end
  end

endmodule

// File: rtl/ofdm_sym_mapper.sv
// QPSK-maps buffered 48-bit payload words onto 24 bins of an NPTS-bin symbol
// and streams the symbol one bin per clock.
//   state | meaning
//   IDLE  | waiting for a buffered word
//   EMIT  | streaming bin r_k of the current symbol
//   GAP   | forced idle cycles between symbols
module ofdm_sym_mapper
  import ofdm_pkg::*;
#(
  parameter int NPTS      = NPTS_DEF,
  parameter int BIN0      = BIN0_DEF,
  parameter int AMP       = 16384,
  parameter int PILOT_BIN = 60,
  parameter int PILOT_EN  = 1,
  parameter int GAP       = 0
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                PushIn,
  input  logic [47:0]         DataIn,
  output logic                Ready,
  output logic                Pushin,
  output logic                FirstData,
  output logic signed [16:0]  DinR,
  output logic signed [16:0]  DinI
);

  localparam int              KW       = $clog2(NPTS);
  localparam logic [KW-1:0]   LP_LAST  = KW'(NPTS - 1);
  localparam logic [KW-1:0]   LP_PILOT = KW'(PILOT_BIN);
  localparam logic [7:0]      LP_GAP   = 8'(GAP);
  localparam sample_t         LP_AMP   = sample_t'(AMP);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [KW-1:0] r_k;
  logic [KW-1:0] w_k_nxt;
  logic [7:0]    r_gap;
  logic [7:0]    w_gap_nxt;
  word_t         r_word;
  word_t         w_head;
  logic          w_pop;
  logic          w_empty;
  logic          w_pushin;
  logic          w_first;
  sample_t       w_re;
  sample_t       w_im;
  logic [4:0]    w_idx;
  iq_t           w_iq;

  ofdm_word_fifo u_fifo (
    .i_clk   (Clk),
    .i_rst_n (Reset),
    .i_push  (PushIn),
    .i_pop   (w_pop),
    .i_data  (DataIn),
    .o_data  (w_head),
    .o_empty (w_empty),
    .o_ready (Ready)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= ST_IDLE;
      r_k     <= '0;
      r_gap   <= '0;
      r_word  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
      r_gap   <= w_gap_nxt;
      if (w_pop) begin
        r_word <= w_head;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_gap_nxt   = r_gap;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_k_nxt     = '0;
          w_state_nxt = ST_EMIT;
        end
      end
      ST_EMIT: begin
        w_k_nxt = r_k + 1'b1;
        if (r_k == LP_LAST) begin
          w_k_nxt = '0;
          if (GAP > 0) begin
            w_gap_nxt   = LP_GAP;
            w_state_nxt = ST_GAP;
          end else if (!w_empty) begin
            w_pop = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        w_gap_nxt = r_gap - 8'd1;
        if (r_gap == 8'd1) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Bin value for the current k; outputs are forced to zero outside EMIT.
  always_comb begin
    w_pushin = 1'b0;
    w_first  = 1'b0;
    w_re     = '0;
    w_im     = '0;
    w_idx    = 5'(int'(r_k) - BIN0);
    w_iq     = qpsk_map(r_word[{w_idx, 1'b0} +: 2], LP_AMP);
    if (r_state == ST_EMIT) begin
      w_pushin = 1'b1;
      w_first  = (r_k == '0);
      if (int'(r_k) >= BIN0 && int'(r_k) < BIN0 + 24) begin
        w_re = w_iq.re;
        w_im = w_iq.im;
      end else if (PILOT_EN != 0 && r_k == LP_PILOT) begin
        w_re = LP_AMP;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Pushin    <= 1'b0;
      FirstData <= 1'b0;
      DinR      <= '0;
      DinI      <= '0;
    end else begin
      Pushin    <= w_pushin;
      FirstData <= w_first;
      DinR      <= w_re;
      DinI      <= w_im;
    end
  end

endmodule

// File: tb/tb_ofdm_sym_mapper.sv
// Scoreboard bench: two mappers (GAP=0 and GAP=5) share clock and reset;
// accepted words are queued and a negedge monitor checks every output bin.
module tb_ofdm_sym_mapper;

  localparam int NPTS  = 128;
  localparam int BIN0  = 4;
  localparam int AMP   = 16384;
  localparam int PILOT = 60;

  logic               Clk   = 1'b0;
  logic               Reset = 1'b0;
  logic               push   [2];
  logic [47:0]        data   [2];
  logic               ready  [2];
  logic               pushin [2];
  logic               first  [2];
  logic signed [16:0] dinr   [2];
  logic signed [16:0] dini   [2];

  int n_pass  = 0;
  int n_total = 0;

  logic [47:0] q0[$];
  logic [47:0] q1[$];
  int          k_m       [2];
  int          zeros     [2];
  bit          in_sym    [2];
  bit          have_prev [2];
  bit          backlog   [2];
  logic [47:0] cur_w     [2];

  always #5 Clk = ~Clk;

  ofdm_sym_mapper #(.GAP(0)) dut0 (
    .Clk(Clk), .Reset(Reset), .PushIn(push[0]), .DataIn(data[0]), .Ready(ready[0]),
    .Pushin(pushin[0]), .FirstData(first[0]), .DinR(dinr[0]), .DinI(dini[0])
  );

  ofdm_sym_mapper #(.GAP(5)) dut1 (
    .Clk(Clk), .Reset(Reset), .PushIn(push[1]), .DataIn(data[1]), .Ready(ready[1]),
    .Pushin(pushin[1]), .FirstData(first[1]), .DinR(dinr[1]), .DinI(dini[1])
  );

  function automatic void chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endfunction

  // Expected bin contents straight from the mapping rules.
  function automatic void ref_bin(input logic [47:0] w, input int k, output int re, output int im);
    re = 0;
    im = 0;
    if (k >= BIN0 && k < BIN0 + 24) begin
      re = w[2*(k-BIN0)]   ? -AMP : AMP;
      im = w[2*(k-BIN0)+1] ? -AMP : AMP;
    end else if (k == PILOT) begin
      re = AMP;
    end
  endfunction

  function automatic int q_size(input int g);
    return (g == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [47:0] q_pop(input int g);
    if (g == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  always @(negedge Clk) begin : mon
    int re, im;
    for (int g = 0; g < 2; g++) begin
      if (!Reset) begin
        chk($sformatf("rst_pushin%0d", g), pushin[g], 0);
        chk($sformatf("rst_first%0d", g), first[g], 0);
        chk($sformatf("rst_dinr%0d", g), int'(dinr[g]), 0);
        chk($sformatf("rst_dini%0d", g), int'(dini[g]), 0);
        chk($sformatf("rst_ready%0d", g), ready[g], 0);
        if (g == 0) q0.delete(); else q1.delete();
        in_sym[g] = 0; have_prev[g] = 0; zeros[g] = 0; k_m[g] = 0;
      end else begin
        if (pushin[g]) begin
          if (!in_sym[g]) begin
            if (q_size(g) == 0) begin
              chk($sformatf("spurious_sym%0d", g), 0, 1);
              cur_w[g] = '0;
            end else begin
              cur_w[g] = q_pop(g);
              if (have_prev[g] && backlog[g])
                chk($sformatf("gap_len%0d", g), zeros[g], (g == 0) ? 0 : 6);
            end
            in_sym[g] = 1; k_m[g] = 0; backlog[g] = 0;
          end
          ref_bin(cur_w[g], k_m[g], re, im);
          chk($sformatf("first%0d_k%0d", g, k_m[g]), first[g], (k_m[g] == 0) ? 1 : 0);
          chk($sformatf("dinr%0d_k%0d", g, k_m[g]), int'(dinr[g]), re);
          chk($sformatf("dini%0d_k%0d", g, k_m[g]), int'(dini[g]), im);
          if (k_m[g] == NPTS - 2) backlog[g] = (q_size(g) > 0);
          k_m[g]++;
          if (k_m[g] == NPTS) begin
            in_sym[g] = 0; have_prev[g] = 1; zeros[g] = 0; k_m[g] = 0;
          end
        end else begin
          chk($sformatf("idle_out%0d", g),
              (first[g] || dinr[g] != 0 || dini[g] != 0) ? 1 : 0, 0);
          if (in_sym[g]) begin
            chk($sformatf("truncated%0d", g), k_m[g], NPTS);
            in_sym[g] = 0;
          end
          zeros[g]++;
        end
        if (push[g] && ready[g]) begin
          if (g == 0) q0.push_back(data[g]); else q1.push_back(data[g]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic send(input int g, input logic [47:0] w);
    int n = 0;
    data[g] = w;
    push[g] = 1'b1;
    while (ready[g] !== 1'b1 && n < 1000) begin
      tick();
      n++;
    end
    if (n >= 1000) chk("send_timeout", n, 0);
    tick();
    push[g] = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((in_sym[0] || in_sym[1] || q0.size() > 0 || q1.size() > 0) && n < 3000) begin
      tick();
      n++;
    end
    chk("drain", (n < 3000) ? 1 : 0, 1);
    repeat (10) tick();
  endtask

  initial begin
    int n;
    int cnt;
    push[0] = 1'b1; push[1] = 1'b1;
    data[0] = 48'hFFFF_FFFF_FFFF; data[1] = 48'h1234_5678_9ABC;
    repeat (3) @(posedge Clk);
    #2;
    Reset = 1'b1; push[0] = 1'b0; push[1] = 1'b0;
    @(negedge Clk);
    chk("ready_pre_edge", ready[0], 0);
    @(negedge Clk);
    chk("ready_rise0", ready[0], 1);
    chk("ready_rise1", ready[1], 1);
    tick();

    // first-sample latency on an all-zero word
    chk("lat_ready", ready[0], 1);
    data[0] = 48'h0; push[0] = 1'b1;
    tick();
    push[0] = 1'b0;
    @(negedge Clk); chk("lat_t0", pushin[0], 0);
    @(posedge Clk); @(negedge Clk); chk("lat_t1", pushin[0], 0);
    @(posedge Clk); @(negedge Clk); chk("lat_t2_first", first[0], 1);
    tick();
    wait_idle();

    send(0, 48'h1);
    wait_idle();
    send(0, 48'h8000_0000_0000);
    wait_idle();

    // back-to-back words, FIFO fills and Ready drops
    send(0, {16'($urandom), $urandom});
    send(0, {16'($urandom), $urandom});
    send(0, {16'($urandom), $urandom});
    chk("ready_full", ready[0], 0);
    wait_idle();

    // GAP=5 instance plus a word offered while Ready is low
    send(1, {16'($urandom), $urandom});
    send(1, {16'($urandom), $urandom});
    send(1, {16'($urandom), $urandom});
    chk("drop_ready_low", ready[1], 0);
    data[1] = 48'hDEAD_BEEF_0BAD; push[1] = 1'b1;
    tick();
    push[1] = 1'b0;
    wait_idle();

    for (int i = 0; i < 10; i++) begin
      send($urandom_range(1, 0), {16'($urandom), $urandom});
      repeat ($urandom_range(150, 0)) tick();
    end
    wait_idle();

    // reset mid-symbol with a word queued behind it
    send(0, {16'($urandom), $urandom});
    send(0, {16'($urandom), $urandom});
    n = 0;
    while (!(in_sym[0] && k_m[0] == 70) && n < 1000) begin
      @(posedge Clk);
      n++;
    end
    chk("reach_bin70", (n < 1000) ? 1 : 0, 1);
    #2;
    Reset = 1'b0;
    repeat (2) tick();
    Reset = 1'b1;
    cnt = 0;
    repeat (300) begin
      @(negedge Clk);
      cnt += int'(pushin[0]) + int'(pushin[1]);
    end
    chk("post_reset_quiet", cnt, 0);
    tick();
    send(0, {16'($urandom), $urandom});
    wait_idle();

    chk("final_q0_empty", q0.size(), 0);
    chk("final_q1_empty", q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
